// File: rtl/cm_serial.sv
// Serial multiply-accumulate processing element: 3-stage pipeline (operand
// capture, truncated 8x8 product, wrapping accumulator with in-band restart).
module cm_serial (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             a,
  input  logic [7:0]             b,
  input  logic                   mux_reset,
  output logic [7:0]             out
);

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 2 * DW;

  logic [DW-1:0] a_r;
  logic [DW-1:0] b_r;
  logic          restart_s1;
  logic [DW-1:0] p;
  logic          restart_s2;
  logic [DW-1:0] acc;
  logic [DW-1:0] p_c;
  logic [DW-1:0] acc_next_c;

  // Full-width product, keeping only the low byte.
  always_comb begin
    p_c = DW'(PW'(a_r) * PW'(b_r));
  end

  // Feedback mux: a restart replaces the sum instead of adding to it.
  always_comb begin
    acc_next_c = acc + p;
    if (restart_s2) begin
      acc_next_c = p;
    end
  end

  // S1: operand and restart flag capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      a_r        <= '0;
      b_r        <= '0;
      restart_s1 <= 1'b0;
    end else begin
      a_r        <= a;
      b_r        <= b;
      restart_s1 <= mux_reset;
    end
  end

  // S2: product register with the flag travelling alongside it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      p          <= '0;
      restart_s2 <= 1'b0;
    end else begin
      p          <= p_c;
      restart_s2 <= restart_s1;
    end
  end

  // S3: accumulator, wraps silently on overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= '0;
    end else begin
      acc <= acc_next_c;
    end
  end

  assign out = acc;

endmodule

// File: tb/tb_cm_serial.sv
// Directed self-checking bench for cm_serial; each check is taken 1 time unit
// after a rising edge and reflects the pair sampled two edges earlier.
module tb_cm_serial;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic       mux_reset;
  logic [7:0] out;

  int errors = 0;
  int checks = 0;

  cm_serial dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .mux_reset (mux_reset),
    .out       (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: out=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drive one pair, let one rising edge sample it, settle just past the edge.
  task automatic cyc(input logic [7:0] ia, input logic [7:0] ib,
                     input logic imr, input logic irst);
    a         = ia;
    b         = ib;
    mux_reset = imr;
    rst       = irst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    a = '0; b = '0; mux_reset = 1'b0; rst = 1'b0;
    #2;

    // Reset held two cycles with a nonzero pair present.
    cyc(8'd12, 8'd5, 1'b0, 1'b0); chk("rst_c0", out, 8'd0);
    cyc(8'd12, 8'd5, 1'b0, 1'b0); chk("rst_c1", out, 8'd0);

    // Basic accumulation, then restart.
    cyc(8'd3, 8'd2, 1'b0, 1'b1);  chk("rel_c0", out, 8'd0);
    cyc(8'd2, 8'd5, 1'b0, 1'b1);  chk("rel_c1", out, 8'd0);
    cyc(8'd5, 8'd3, 1'b0, 1'b1);  chk("acc_6", out, 8'd6);
    cyc(8'd2, 8'd7, 1'b0, 1'b1);  chk("acc_16", out, 8'd16);
    cyc(8'd3, 8'd3, 1'b1, 1'b1);  chk("acc_31", out, 8'd31);
    cyc(8'd2, 8'd4, 1'b0, 1'b1);  chk("acc_45", out, 8'd45);
    cyc(8'd0, 8'd0, 1'b0, 1'b1);  chk("restart_9", out, 8'd9);
    cyc(8'd0, 8'd0, 1'b0, 1'b1);  chk("after_17", out, 8'd17);
    cyc(8'd0, 8'd0, 1'b0, 1'b1);  chk("hold_17", out, 8'd17);

    // Wraparound and product truncation.
    cyc(8'd0, 8'd0, 1'b0, 1'b0);   chk("wrap_rst", out, 8'd0);
    cyc(8'd15, 8'd17, 1'b0, 1'b1); chk("wrap_c0", out, 8'd0);
    cyc(8'd1, 8'd1, 1'b0, 1'b1);   chk("wrap_c1", out, 8'd0);
    cyc(8'd16, 8'd16, 1'b0, 1'b1); chk("wrap_255", out, 8'd255);
    cyc(8'd17, 8'd16, 1'b1, 1'b1); chk("wrap_0", out, 8'd0);
    cyc(8'd0, 8'd0, 1'b0, 1'b1);   chk("trunc_256", out, 8'd0);
    cyc(8'd0, 8'd0, 1'b0, 1'b1);   chk("trunc_272", out, 8'd16);

    // Mid-operation reset drops the sum and in-flight pairs.
    cyc(8'd0, 8'd0, 1'b0, 1'b0); chk("mid_pre_rst", out, 8'd0);
    cyc(8'd5, 8'd5, 1'b0, 1'b1); chk("mid_c0", out, 8'd0);
    cyc(8'd1, 8'd2, 1'b0, 1'b1); chk("mid_c1", out, 8'd0);
    cyc(8'd3, 8'd4, 1'b0, 1'b1); chk("mid_25", out, 8'd25);
    cyc(8'd2, 8'd2, 1'b0, 1'b1); chk("mid_27", out, 8'd27);
    cyc(8'd7, 8'd7, 1'b0, 1'b0); chk("mid_rst", out, 8'd0);
    cyc(8'd6, 8'd6, 1'b0, 1'b1); chk("mid_lost0", out, 8'd0);
    cyc(8'd1, 8'd1, 1'b0, 1'b1); chk("mid_lost1", out, 8'd0);
    cyc(8'd0, 8'd0, 1'b0, 1'b1); chk("mid_36", out, 8'd36);
    cyc(8'd0, 8'd0, 1'b0, 1'b1); chk("mid_37", out, 8'd37);

    // Reset beats a simultaneous restart flag.
    cyc(8'd4, 8'd4, 1'b1, 1'b0); chk("prio_rst", out, 8'd0);
    cyc(8'd2, 8'd3, 1'b0, 1'b1); chk("prio_c0", out, 8'd0);
    cyc(8'd0, 8'd0, 1'b0, 1'b1); chk("prio_c1", out, 8'd0);
    cyc(8'd0, 8'd0, 1'b0, 1'b1); chk("prio_6", out, 8'd6);
    cyc(8'd0, 8'd0, 1'b0, 1'b1); chk("prio_hold", out, 8'd6);

    // Back-to-back restart pulses.
    cyc(8'd3, 8'd5, 1'b1, 1'b1); chk("b2b_c0", out, 8'd6);
    cyc(8'd2, 8'd2, 1'b1, 1'b1); chk("b2b_c1", out, 8'd6);
    cyc(8'd4, 8'd1, 1'b1, 1'b1); chk("b2b_15", out, 8'd15);
    cyc(8'd0, 8'd0, 1'b0, 1'b1); chk("b2b_4a", out, 8'd4);
    cyc(8'd0, 8'd0, 1'b0, 1'b1); chk("b2b_4b", out, 8'd4);
    cyc(8'd0, 8'd0, 1'b0, 1'b1); chk("b2b_hold", out, 8'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cm_serial.md
# cm_serial

Serial multiply-accumulate processing element for the computation datapath. Each clock it takes one 8-bit operand pair, multiplies them, and adds the product into an 8-bit running sum. An in-band restart flag begins a new sum without a reset. The running sum is presented on `out`, and instances chain serially in the PE array.

## Interface

Parameters: none. Widths are fixed at 8 bits.

- `clk`  in  1  Single clock. All state updates on the rising edge.
- `rst`  in  1  Synchronous, active-low reset. Sampled on the rising edge of `clk`.
- `a`  in  8  Unsigned multiplicand.
- `b`  in  8  Unsigned multiplier.
- `mux_reset`  in  1  Restart flag for the sample it arrives with. When 1, that product replaces the running sum instead of being added to it.
- `out`  out  8  Registered accumulator value.

## Operation

- Three-stage pipeline:
  - S1: registers `a`, `b` and `mux_reset`.
  - S2: registers `p = (a_r * b_r) mod 256` plus the delayed restart flag.
  - S3: the accumulator `acc`.
- The multiply is unsigned 8x8. The full 16-bit product is formed, and only bits [7:0] are kept.
- Accumulator update (the feedback multiplexer):
  - If `restart_s2` = 1: `acc <= p`.
  - Otherwise: `acc <= (acc + p) mod 256`.
- Overflow wraps silently. There is no saturation and no carry/overflow output.
- `mux_reset` travels through the pipeline with its operand pair, so the restart applies exactly to the product of the pair sampled in the same cycle.
- `out` is driven directly from `acc`. There is no combinational path from any input to `out`.
- Reset (`rst` = 0 at a rising edge) clears S1, S2 and `acc` to 0, including the flag registers.
  - Reset has priority over every other input.
  - Reset asserted mid-accumulation discards the in-flight pairs and the sum.
- After reset, the first accumulation starts from 0, so `mux_reset` is not required on the first pair.
- Inputs are sampled every cycle; there is no valid/ready handshake. To hold the sum, drive `a` = 0 or `b` = 0.

## Timing

- A pair (`a`, `b`, `mux_reset`) sampled at edge N updates the S2 product register at edge N+1 and is reflected in `out` after edge N+2. Latency is 2 cycles from the sampling edge.
- Throughput is one pair per cycle.
- Reset:
  - `out` = 0 from the first edge with `rst` = 0 and for every cycle `rst` stays low.
  - On release, the first pair sampled (edge R) appears in `out` after edge R+2.
  - `out` stays 0 until then, because the pipeline holds zeros.
- Simultaneous `rst` = 0 and `mux_reset` = 1: reset wins, and the flag is dropped.
- Back-to-back `mux_reset` pulses: each affected cycle, `out` equals only the product sampled 2 edges earlier.

## Test plan

- Reset: hold `rst` = 0 for 2 cycles with `a` = 12, `b` = 5 → `out` = 0 during reset and for the first 2 cycles after release.
- Basic accumulation: after reset, apply (3,2), (2,5), (5,3), (2,7), one per cycle → `out` = 6, 16, 31, 45 on successive cycles, starting 2 cycles after the first pair is sampled.
- Restart: after reaching 45, apply (3,3) with `mux_reset` = 1, then (2,4) with `mux_reset` = 0 → `out` = 9, then 17.
- Wraparound:
  - Apply (15,17) from reset → 255.
  - Then (1,1) → 0.
  - Then (16,16) → 0, because the product 256 truncates to 0.
- Mid-operation reset: accumulate to a nonzero value, pulse `rst` = 0 for 1 cycle while pairs are streaming → `out` = 0, and in-flight pairs are lost. Accumulation then resumes from 0 with pairs sampled after release.
- Reset priority: assert `rst` = 0 and `mux_reset` = 1 together with (4,4) → `out` remains 0, and the subsequent sum starts from 0.
